// File: rtl/timer_chain_pkg.sv
// Shared types and record geometry for the timer-chain readout sequencer.
package timer_chain_pkg;

  localparam int REC_BITS   = 33;
  localparam int REC_DATA_W = 32;
  localparam int INDEX_W    = 6;
  localparam int BIT_CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ARMED,
    SHIFT_LOW,
    SHIFT_HIGH,
    EMIT
  } state_e;

endpackage

// File: rtl/chain_shift_phy.sv
// data_clock phase generator plus the sampler/shift register that reassembles
// one 33-bit record from the chain tail.
module chain_shift_phy
  import timer_chain_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic                 level_i,
  input  logic                 sample_i,
  input  logic                 rise_i,
  input  logic [BIT_CNT_W-1:0] bit_idx_i,
  input  logic                 shiftout_i,
  output logic                 phase_end_o,
  output logic                 data_clock_o,
  output logic [REC_BITS-1:0]  record_o
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [PH_W-1:0]     phase_q;
  logic                data_clock_q;
  logic [REC_BITS-1:0] shift_q;

  assign phase_end_o  = step_i && (phase_q == PH_W'(HALF_PERIOD - 1));
  assign data_clock_o = data_clock_q;
  assign record_o     = shift_q;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; shift_q is reset too because rec_data reads it directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q      <= '0;
      data_clock_q <= 1'b0;
      shift_q      <= '0;
    end else if (clear_i || !step_i) begin
      phase_q      <= '0;
      data_clock_q <= 1'b0;
    end else if (phase_end_o) begin
      phase_q      <= '0;
      // The clock level changes exactly when the FSM changes phase state.
      data_clock_q <= !level_i && rise_i;
      if (!level_i && sample_i) shift_q[bit_idx_i] <= shiftout_i;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_chain_readout.sv
// Arm / wait / readout sequencer for a daisy chain of trigger timers, delivering
// one record per timer on a valid/ready stream.
module timer_chain_readout
  import timer_chain_pkg::*;
#(
  parameter int N_TIMERS    = 4,
  parameter int HALF_PERIOD = 4,
  parameter int ARM_CYCLES  = 8,
  parameter int TIMEOUT_W   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TIMEOUT_W-1:0]  timeout,
  input  logic [N_TIMERS-1:0]   timer_ready,
  output logic                  timer_reset_n,
  output logic                  data_clock,
  output logic                  data_shiftin,
  input  logic                  data_shiftout,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [REC_DATA_W-1:0] rec_data,
  output logic                  rec_enabled,
  output logic [INDEX_W-1:0]    rec_index,
  output logic                  busy,
  output logic                  timed_out
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [INDEX_W-1:0]   LAST_IDX = INDEX_W'(N_TIMERS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(REC_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] PAST_BIT = BIT_CNT_W'(REC_BITS);

  state_e               state_q;
  logic [ARM_W-1:0]     arm_cnt_q;
  logic [TIMEOUT_W-1:0] wait_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [INDEX_W-1:0]   rec_index_q;
  logic                 timer_reset_n_q;
  logic                 rec_valid_q;
  logic                 busy_q;
  logic                 timed_out_q;

  logic                last_rec;
  logic                do_sample;
  logic                do_rise;
  logic                phase_end;
  logic [REC_BITS-1:0] record;

  assign last_rec  = (rec_index_q == LAST_IDX);
  assign do_sample = (state_q == SHIFT_LOW) && (bit_cnt_q != PAST_BIT);
  // The final bit of the final record is sampled without a following edge.
  assign do_rise   = do_sample && !(last_rec && (bit_cnt_q == LAST_BIT));

  chain_shift_phy #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_phy (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (abort),
    .step_i       (state_q inside {SHIFT_LOW, SHIFT_HIGH}),
    .level_i      (state_q == SHIFT_HIGH),
    .sample_i     (do_sample),
    .rise_i       (do_rise),
    .bit_idx_i    (bit_cnt_q),
    .shiftout_i   (data_shiftout),
    .phase_end_o  (phase_end),
    .data_clock_o (data_clock),
    .record_o     (record)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      arm_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      rec_index_q     <= '0;
      timer_reset_n_q <= 1'b0;
      rec_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      timed_out_q     <= 1'b0;
    end else if (abort) begin
      state_q         <= IDLE;
      timer_reset_n_q <= 1'b0;
      rec_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q     <= ARM;
          arm_cnt_q   <= '0;
          rec_index_q <= '0;
          timed_out_q <= 1'b0;
          busy_q      <= 1'b1;
        end
        ARM: if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
          state_q         <= ARMED;
          timer_reset_n_q <= 1'b1;
          wait_cnt_q      <= '0;
        end else begin
          arm_cnt_q <= arm_cnt_q + 1'b1;
        end
        ARMED: if (&timer_ready) begin
          state_q   <= SHIFT_LOW;
          bit_cnt_q <= '0;
        end else if ((timeout != '0) && (wait_cnt_q == timeout - 1'b1)) begin
          state_q     <= SHIFT_LOW;
          bit_cnt_q   <= '0;
          timed_out_q <= 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        SHIFT_LOW: if (phase_end) begin
          if (!do_rise) begin
            state_q     <= EMIT;
            rec_valid_q <= 1'b1;
          end else begin
            state_q <= SHIFT_HIGH;
          end
        end
        SHIFT_HIGH: if (phase_end) begin
          state_q   <= SHIFT_LOW;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        EMIT: if (rec_ready) begin
          rec_valid_q <= 1'b0;
          if (last_rec) begin
            state_q         <= IDLE;
            timer_reset_n_q <= 1'b0;
            busy_q          <= 1'b0;
          end else begin
            state_q     <= SHIFT_LOW;
            rec_index_q <= rec_index_q + 1'b1;
            bit_cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign timer_reset_n = timer_reset_n_q;
  assign data_shiftin  = 1'b0;
  assign rec_valid     = rec_valid_q;
  assign rec_data      = record[REC_BITS-1:1];
  assign rec_enabled   = record[0];
  assign rec_index     = rec_index_q;
  assign busy          = busy_q;
  assign timed_out     = timed_out_q;

endmodule

// File: tb/tb_timer_chain_readout.sv
// Randomized bench for timer_chain_readout with a behavioural trigger-timer chain.
module tb_timer_chain_readout;

  localparam int N      = 2;
  localparam int HALF   = 4;
  localparam int ARMC   = 8;
  localparam int TW     = 24;
  localparam int BUDGET = 6000;

  logic          clk = 1'b0;
  logic          reset, start, abort, rec_ready;
  logic [TW-1:0] timeout_i;
  logic [N-1:0]  timer_ready;
  logic          timer_reset_n, data_clock, data_shiftin, data_shiftout;
  logic          rec_valid, rec_enabled, busy, timed_out;
  logic [31:0]   rec_data;
  logic [5:0]    rec_index;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timer_chain_readout #(
    .N_TIMERS (N), .HALF_PERIOD (HALF), .ARM_CYCLES (ARMC), .TIMEOUT_W (TW)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .timeout (timeout_i), .timer_ready (timer_ready),
    .timer_reset_n (timer_reset_n), .data_clock (data_clock),
    .data_shiftin (data_shiftin), .data_shiftout (data_shiftout),
    .rec_valid (rec_valid), .rec_ready (rec_ready), .rec_data (rec_data),
    .rec_enabled (rec_enabled), .rec_index (rec_index),
    .busy (busy), .timed_out (timed_out)
  );

  // Behavioural trigger timers: free-running counter from reset release, latch on
  // trigger, unfired timers load -2 on the first detected data_clock rise.
  int          trig_t [N];   // -1 = never fires
  logic [N-1:0] en_cfg;
  logic [32:0] t_sr  [N];
  logic [32:0] t_eff [N];
  logic        t_in  [N];
  logic [31:0] t_cnt = '0;
  logic [N-1:0] t_fired = '0;
  logic [2:0]  t_sync = '0;
  logic        t_first_done = 1'b0;
  logic        t_edge;

  assign t_edge        = t_sync[1] & ~t_sync[2];
  assign timer_ready   = t_fired;
  assign data_shiftout = t_sr[0][0];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      t_eff[i] = (!t_first_done && !t_fired[i]) ? {32'hFFFF_FFFE, en_cfg[i]} : t_sr[i];
    end
    for (int i = 0; i < N; i++) begin
      t_in[i] = (i == N - 1) ? data_shiftin : t_eff[(i + 1) % N][0];
    end
  end

  always @(negedge clk) begin
    if (!timer_reset_n) begin
      t_cnt        <= '0;
      t_fired      <= '0;
      t_sync       <= '0;
      t_first_done <= 1'b0;
      for (int i = 0; i < N; i++) t_sr[i] <= '0;
    end else begin
      t_cnt  <= t_cnt + 1;
      t_sync <= {t_sync[1:0], data_clock};
      for (int i = 0; i < N; i++) begin
        if (!t_first_done && !t_fired[i] && trig_t[i] >= 0 && t_cnt == 32'(trig_t[i])) begin
          t_fired[i] <= 1'b1;
          t_sr[i]    <= {t_cnt, en_cfg[i]};
        end
      end
      if (t_edge) begin
        t_first_done <= 1'b1;
        for (int i = 0; i < N; i++) t_sr[i] <= {t_in[i], t_eff[i][32:1]};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full start..IDLE cycle with record, timing and edge-count checks.
  task automatic run_cycle(input string name, input logic [TW-1:0] to, input int stall,
                           input bit rnd, input bit inject, input bit exp_to);
    logic [31:0] exp_data [N];
    logic [39:0] held;
    int  k = 0, rises = 0, cyc = 0, arm_at = -1, rise_at = -1, stall_left = stall;
    bit  hold = 0;
    logic prev_dclk = 1'b0;
    for (int i = 0; i < N; i++) exp_data[i] = (trig_t[i] >= 0) ? 32'(trig_t[i]) : 32'hFFFF_FFFE;
    timeout_i = to;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < BUDGET) begin
      if (timer_reset_n && arm_at < 0) arm_at = cyc;
      if (data_clock && !prev_dclk) begin
        rises++;
        if (rise_at < 0) rise_at = cyc;
      end
      prev_dclk = data_clock;
      if (hold) check({name, ".stable"}, {rec_valid, rec_index, rec_enabled, rec_data}, {1'b1, held[38:0]});
      hold = 1'b0;
      if (!busy && k == N) break;
      if (rec_valid) begin
        check({name, ".emit_dclk"}, data_clock, 1'b0);
        if (stall_left > 0) begin
          rec_ready = 1'b0;
          stall_left--;
        end else begin
          rec_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (rec_ready) begin
          check($sformatf("%s.idx%0d", name, k), rec_index, k);
          check($sformatf("%s.data%0d", name, k), rec_data, exp_data[k]);
          check($sformatf("%s.en%0d", name, k), rec_enabled, en_cfg[k]);
          k++;
        end else begin
          hold = 1'b1;
          held = {1'b1, rec_index, rec_enabled, rec_data};
        end
      end else begin
        rec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = inject && busy && ($urandom_range(0, 40) == 0);
      tick();
      cyc++;
    end
    start = 1'b0;
    if (cyc >= BUDGET) begin
      check({name, ".budget"}, 0, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end else begin
      check({name, ".rstn_idle"}, timer_reset_n, 1'b0);
      check({name, ".valid_idle"}, rec_valid, 1'b0);
      check({name, ".timed_out"}, timed_out, exp_to);
      check({name, ".rises"}, rises, 33 * N - 1);
      check({name, ".arm_len"}, arm_at, ARMC);
      if (exp_to) check({name, ".to_len"}, rise_at - arm_at, int'(to) + HALF);
    end
  endtask

  task automatic wait_for(input string name, input bit want_valid);
    int n = 0;
    while (n < BUDGET && (want_valid ? !rec_valid : !data_clock)) begin
      tick();
      n++;
    end
    if (n >= BUDGET) check({name, ".wait"}, 0, 1);
  endtask

  initial begin
    logic [TW-1:0] to;
    int tmax;
    reset = 1'b0; start = 1'b0; abort = 1'b0; rec_ready = 1'b1; timeout_i = '0;
    trig_t[0] = -1; trig_t[1] = -1; en_cfg = '1;
    repeat (3) tick();
    check("rst.state", {timer_reset_n, data_clock, data_shiftin, rec_valid, rec_enabled, busy, timed_out}, '0);
    check("rst.data", rec_data, 0);
    check("rst.index", rec_index, 0);
    reset = 1'b1;
    tick();
    check("idle.busy", busy, 1'b0);

    trig_t[0] = 100; trig_t[1] = 250; en_cfg = 2'b11;
    run_cycle("dir_ready", '0, 0, 0, 0, 0);

    trig_t[0] = 100; trig_t[1] = -1; en_cfg = 2'b11;
    run_cycle("dir_timeout", TW'(1000), 0, 0, 0, 1);

    trig_t[0] = 60; trig_t[1] = 80; en_cfg = 2'b10;
    run_cycle("stall", '0, 50, 0, 0, 0);

    for (int it = 0; it < 8; it++) begin
      en_cfg    = N'($urandom_range(0, 3));
      trig_t[0] = $urandom_range(20, 300);
      trig_t[1] = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(20, 300);
      tmax = (trig_t[0] > trig_t[1]) ? trig_t[0] : trig_t[1];
      if (trig_t[1] < 0) to = TW'(trig_t[0] + $urandom_range(30, 300));
      else to = ($urandom_range(0, 1) == 1) ? '0 : TW'(tmax + $urandom_range(30, 300));
      run_cycle($sformatf("rnd%0d", it), to, 0, 1, 1, trig_t[1] < 0);
    end

    trig_t[0] = 30; trig_t[1] = 40;
    timeout_i = '0; rec_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_for("abort", 0);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.dclk", data_clock, 1'b0);
    check("abort.rstn", timer_reset_n, 1'b0);
    check("abort.valid", rec_valid, 1'b0);

    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_idle.busy", busy, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check("busy_after_start", busy, 1'b1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("start_abort_busy.busy", busy, 1'b0);
    check("start_abort_busy.rstn", timer_reset_n, 1'b0);

    trig_t[0] = 30; trig_t[1] = -1; en_cfg = 2'b11;
    timeout_i = TW'(200); rec_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_for("rst_emit", 1);
    check("rst_emit.pre_to", timed_out, 1'b1);
    check("rst_emit.pre_data", rec_data, 30);
    reset = 1'b0; tick();
    check("rst_emit.state", {timer_reset_n, data_clock, data_shiftin, rec_valid, rec_enabled, busy, timed_out}, '0);
    check("rst_emit.data", rec_data, 0);
    check("rst_emit.index", rec_index, 0);
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
